// File: rtl/stream_pool2d.sv
// Streaming 2x2 stride-2 pooling over a raster valid/ready pixel stream.
// Optional POOL_AVG_EN adds pool_mode for averaging instead of max.
module stream_pool2d #(
   parameter int DATA_W = 22,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              frame_done,
`ifdef POOL_AVG_EN
   input  logic              pool_mode,
`endif
   output logic              busy
);

   localparam int CW  = $clog2(IMG_W);
   localparam int RW  = $clog2(IMG_H);
   localparam int NLB = IMG_W / 2;
   localparam int AW  = (NLB > 1) ? $clog2(NLB) : 1;
`ifdef POOL_AVG_EN
   localparam int LB_W = DATA_W + 1;
`else
   localparam int LB_W = DATA_W;
`endif

   logic [CW-1:0]     r_col;
   logic [RW-1:0]     r_row;
   logic [DATA_W-1:0] r_p;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_last;
   logic [LB_W-1:0]   r_lb [NLB];

   logic              w_acc;
   logic              w_load;
   logic              w_lb_we;
   logic              w_col_last;
   logic              w_row_last;
   logic              w_first;
   logic [AW-1:0]     w_idx;
   logic [LB_W-1:0]   w_lbv;
   logic [DATA_W-1:0] w_lbm;
   logic [DATA_W-1:0] w_pair_max;
   logic [DATA_W-1:0] w_max;
   logic [LB_W-1:0]   w_lb_wr;
   logic [DATA_W-1:0] w_res;

   assign in_ready   = !r_out_valid || out_ready;
   assign w_acc      = in_valid && in_ready;
   assign w_col_last = (r_col == CW'(IMG_W - 1));
   assign w_row_last = (r_row == RW'(IMG_H - 1));
   assign w_first    = (r_col == '0) && (r_row == '0);
   assign w_load     = w_acc && r_col[0] && r_row[0];
   assign w_lb_we    = w_acc && r_col[0] && !r_row[0];
   assign w_idx      = AW'(r_col >> 1);
   assign w_lbv      = r_lb[w_idx];
   assign w_lbm      = w_lbv[DATA_W-1:0];
   assign w_pair_max = (r_p > in_data) ? r_p : in_data;
   assign w_max      = (w_lbm > w_pair_max) ? w_lbm : w_pair_max;

`ifdef POOL_AVG_EN
   logic              r_mode;
   logic              w_mode;
   logic [DATA_W:0]   w_pair_sum;
   logic [DATA_W+1:0] w_sum4;

   assign w_mode     = w_first ? pool_mode : r_mode;
   assign w_pair_sum = {1'b0, r_p} + {1'b0, in_data};
   assign w_sum4     = {1'b0, w_lbv} + {1'b0, w_pair_sum};
   assign w_lb_wr    = w_mode ? w_pair_sum : {1'b0, w_pair_max};
   assign w_res      = w_mode ? w_sum4[DATA_W+1:2] : w_max;

   // Mode latches on the frame's first pixel and stays for the whole frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode <= 1'b0;
      end else if (w_acc && w_first) begin
         r_mode <= pool_mode;
      end
   end
`else
   assign w_lb_wr = w_pair_max;
   assign w_res   = w_max;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col       <= '0;
         r_row       <= '0;
         r_p         <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_last      <= 1'b0;
      end else begin
         if (w_acc) begin
            if (!r_col[0]) begin
               r_p <= in_data;
            end
            if (w_col_last) begin
               r_col <= '0;
               r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
         // A fresh result wins over the handshake that retires the old one.
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_res;
            r_last      <= w_row_last && w_col_last;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_lb_we) begin
         r_lb[w_idx] <= w_lb_wr;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign frame_done = r_out_valid && out_ready && r_last;
   assign busy       = (r_col != '0) || (r_row != '0) || r_out_valid;

endmodule

// File: tb/tb_stream_pool2d.sv
// Scoreboard bench for stream_pool2d: reference pooling model feeds a queue,
// a monitor pops it on every output handshake.
module tb_stream_pool2d;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [21:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [21:0] out_data;
   logic        frame_done;
   logic        busy;
`ifdef POOL_AVG_EN
   logic        pool_mode = 1'b0;
`endif

   typedef struct {
      logic [21:0] d;
      logic        last;
   } exp_t;

   exp_t        q[$];
   logic [21:0] img [8][8];
   int          n_chk = 0;
   int          n_pass = 0;
   int          fd_cnt = 0;
   bit          stall_req = 0;
   bit          rnd_rdy = 0;
   bit          rnd_gap = 0;
   logic [21:0] held;

   stream_pool2d #(.DATA_W(22), .IMG_W(8), .IMG_H(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .frame_done (frame_done),
`ifdef POOL_AVG_EN
      .pool_mode  (pool_mode),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, longint act, longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_done) fd_cnt++;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("spurious_out_queue", q.size(), 1);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("out_data", longint'(out_data), longint'(e.d));
               chk("frame_done", longint'(frame_done), longint'(e.last));
            end
         end else if (frame_done) begin
            chk("frame_done_idle", longint'(frame_done), 0);
         end
      end
   end

   initial forever begin
      @(posedge clk); #1;
      if (stall_req && out_valid && rst_n) begin
         held = out_data;
         out_ready = 1'b0;
         repeat (5) begin
            @(negedge clk);
            chk("stall_hold", longint'(out_data), longint'(held));
            chk("stall_in_ready", longint'(in_ready), 0);
            chk("stall_valid", longint'(out_valid), 1);
            @(posedge clk); #1;
         end
         out_ready = 1'b1;
         stall_req = 0;
      end else begin
         out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   task automatic send(input logic [21:0] d);
      bit ok;
      if (rnd_gap && $urandom_range(0, 3) == 0) begin
         in_valid = 1'b0;
         in_data = 22'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data = d;
      ok = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Push expectations for every window completed within the first n pixels.
   task automatic run_frame(input int n, input bit avg);
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            longint a, b, e, f, v;
            exp_t x;
            a = img[2*r][2*c];
            b = img[2*r][2*c+1];
            e = img[2*r+1][2*c];
            f = img[2*r+1][2*c+1];
            if (avg) begin
               v = (a + b + e + f) / 4;
            end else begin
               v = a;
               if (b > v) v = b;
               if (e > v) v = e;
               if (f > v) v = f;
            end
            x.d = 22'(v);
            x.last = (r == 3) && (c == 3);
            if ((2*r+1)*8 + 2*c + 1 < n) q.push_back(x);
         end
      end
`ifdef POOL_AVG_EN
      pool_mode = avg;
`endif
      for (int i = 0; i < n; i++) send(img[i/8][i%8]);
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && q.size() != 0; k++) @(posedge clk);
      chk("drain_queue_empty", q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_data", longint'(out_data), 0);
      chk("rst_frame_done", longint'(frame_done), 0);
      chk("rst_busy", longint'(busy), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_busy_after", longint'(busy), 0);
      @(posedge clk); #1;
   endtask

   task automatic set_ramp();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            img[r][c] = 22'(r * 8 + c);
   endtask

   task automatic set_zero();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            img[r][c] = '0;
   endtask

   initial begin
      int fd0;
      do_reset();

      set_ramp();
      fd0 = fd_cnt;
      run_frame(64, 0);
      drain();
      chk("t1_fd_count", fd_cnt - fd0, 1);

      stall_req = 1;
      run_frame(64, 0);
      drain();
      chk("t2_stall_seen", longint'(stall_req), 0);

      set_zero();
      img[1][1] = 22'h3FFFFF;
      run_frame(64, 0);
      drain();

      set_ramp();
      run_frame(20, 0);
      drain();
      do_reset();
      run_frame(64, 0);
      drain();

      fd0 = fd_cnt;
      run_frame(64, 0);
      run_frame(64, 0);
      drain();
      chk("t5_fd_count", fd_cnt - fd0, 2);

`ifdef POOL_AVG_EN
      set_zero();
      img[0][0] = 22'd66;
      img[0][1] = 22'd43;
      img[1][1] = 22'd23;
      run_frame(64, 1);
      run_frame(64, 0);
      drain();
`endif

      rnd_rdy = 1;
      rnd_gap = 1;
      fd0 = fd_cnt;
      for (int f = 0; f < 6; f++) begin
         for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
               img[r][c] = 22'($urandom);
`ifdef POOL_AVG_EN
         run_frame(64, 1'($urandom_range(0, 1)));
`else
         run_frame(64, 0);
`endif
      end
      drain();
      chk("rand_fd_count", fd_cnt - fd0, 6);
      rnd_rdy = 0;
      rnd_gap = 0;
      repeat (4) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
